// File: rtl/mem_arb_ram_pkg.sv
// Shared constants, response header type and sizing helpers for the
// multi-channel arbitrated RAM.
package mem_arb_ram_pkg;

   localparam int unsigned MAX_CH  = 8;
   localparam int unsigned MAX_LAT = 3;
   localparam int unsigned CH_W    = $clog2(MAX_CH);

   // Per-response control; the data word is appended by the top because its
   // width is a module parameter.
   typedef struct packed {
      logic            valid;
      logic [CH_W-1:0] ch;
      logic            err;
   } rsp_hdr_t;

   function automatic int unsigned be_w(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_ram_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is accepted.
module rr_arbiter
   import mem_arb_ram_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   localparam int unsigned IW = idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic              accept,
   output logic [NUM_CH-1:0] grant,
   output logic [IW-1:0]     grant_idx
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = IW'((32'(ptr) + i) % NUM_CH);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (accept && found) begin
         if ((32'(grant_idx) + 32'd1) == NUM_CH) begin
            ptr <= '0;
         end else begin
            ptr <= grant_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arb_ram.sv
// NUM_CH-channel request/response RAM: round-robin accept of one request per
// cycle, byte-strobed writes, RD_LAT-deep response pipeline, range errors.
module mem_arb_ram
   import mem_arb_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_SIZE   = 16,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned RD_LAT     = 1,
   localparam int unsigned BW = be_w(DATA_WIDTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            req_valid,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH-1:0]            req_wr,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_CH*BW-1:0]         req_be,
   output logic [NUM_CH-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]        rsp_rdata,
   output logic                         rsp_err
);

   localparam int unsigned IW  = idx_w(NUM_CH);
   localparam int unsigned MW  = idx_w(MEM_SIZE);
   localparam int unsigned LAT = (RD_LAT > MAX_LAT) ? MAX_LAT : ((RD_LAT < 1) ? 1 : RD_LAT);

   typedef struct packed {
      rsp_hdr_t              hdr;
      logic [DATA_WIDTH-1:0] data;
   } rsp_t;

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

   logic [NUM_CH-1:0]     grant;
   logic [IW-1:0]         gidx;
   logic                  accept;

   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BW-1:0]         sel_be;
   logic                  in_range;
   logic [MW-1:0]         mem_idx;

   rsp_t                  stage_in;
   rsp_t                  pipe [LAT];
   rsp_t                  head;

   // Nothing is accepted while reset is held, even though the arbiter's
   // grant is purely combinational.
   assign accept    = (|req_valid) && !reset;
   assign req_ready = reset ? '0 : grant;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (gidx)
   );

   always_comb begin
      sel_wr    = req_wr[gidx];
      sel_addr  = req_addr[32'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_wdata = req_wdata[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      sel_be    = req_be[32'(gidx)*BW +: BW];
      in_range  = 32'(sel_addr) < MEM_SIZE;
      mem_idx   = MW'(sel_addr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned w = 0; w < MEM_SIZE; w++) begin
            mem[w] <= '0;
         end
      end else if (accept && sel_wr && in_range) begin
         for (int unsigned b = 0; b < BW; b++) begin
            if (sel_be[b]) begin
               mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Read data is taken from storage before this edge's write lands; the
   // single-accept-per-cycle rule means no same-cycle hazard exists.
   always_comb begin
      stage_in           = '0;
      stage_in.hdr.valid = accept;
      stage_in.hdr.ch    = CH_W'(gidx);
      stage_in.hdr.err   = accept && !in_range;
      stage_in.data      = (accept && !sel_wr && in_range) ? mem[mem_idx] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < LAT; s++) begin
            pipe[s] <= '0;
         end
      end else begin
         pipe[0] <= stage_in;
         for (int unsigned s = 1; s < LAT; s++) begin
            pipe[s] <= pipe[s-1];
         end
      end
   end

   assign head      = pipe[LAT-1];
   assign rsp_valid = head.hdr.valid ? (NUM_CH'(1) << head.hdr.ch) : '0;
   assign rsp_rdata = head.hdr.valid ? head.data : '0;
   assign rsp_err   = head.hdr.valid && head.hdr.err;

endmodule

// File: tb/tb_mem_arb_ram.sv
// Scoreboard bench for mem_arb_ram: three instances cover default settings,
// a 12-word/latency-3 build and a latency-2 build.
module tb_mem_arb_ram;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset     [3];
   logic [1:0]  req_valid [3];
   logic [1:0]  req_ready [3];
   logic [1:0]  req_wr    [3];
   logic [7:0]  req_addr  [3];
   logic [63:0] req_wdata [3];
   logic [7:0]  req_be    [3];
   logic [1:0]  rsp_valid [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   typedef struct {
      int          inst;
      int          ch;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model [3][16];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          mon_on = 1'b0;

   mem_arb_ram u_dut0 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   mem_arb_ram #(.MEM_SIZE(12), .RD_LAT(3)) u_dut1 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   mem_arb_ram #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_wr(req_wr[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   always @(posedge clk) cyc = cyc + 1;

   function automatic int lat(input int k);
      return (k == 1) ? 3 : ((k == 2) ? 2 : 1);
   endfunction

   function automatic int ms(input int k);
      return (k == 1) ? 12 : 16;
   endfunction

   function automatic int find_head(input int k);
      for (int j = 0; j < sb.size(); j++) begin
         if (sb[j].inst == k) return j;
      end
      return -1;
   endfunction

   // Response monitor: pops the oldest expectation of the instance.
   always @(negedge clk) begin
      int h;
      if (mon_on) begin
         for (int k = 0; k < 3; k++) begin
            h = find_head(k);
            if (h >= 0 && sb[h].cyc < cyc) begin
               total++; bad++;
               $display("FAIL rsp_missing inst=%0d ch=%0d got none want at cyc %0d (now %0d)",
                        k, sb[h].ch, sb[h].cyc, cyc);
               sb.delete(h);
               h = find_head(k);
            end
            total++;
            if (rsp_valid[k] !== 2'b00) begin
               if (h < 0) begin
                  bad++;
                  $display("FAIL rsp_unexpected inst=%0d got valid=%b data=%h err=%b want no response",
                           k, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
               end else begin
                  if (rsp_valid[k] !== (2'b01 << sb[h].ch) || rsp_rdata[k] !== sb[h].data ||
                      rsp_err[k] !== sb[h].err || cyc != sb[h].cyc) begin
                     bad++;
                     $display("FAIL rsp_check inst=%0d got valid=%b data=%h err=%b cyc=%0d want valid=%b data=%h err=%b cyc=%0d",
                              k, rsp_valid[k], rsp_rdata[k], rsp_err[k], cyc,
                              2'b01 << sb[h].ch, sb[h].data, sb[h].err, sb[h].cyc);
                  end
                  sb.delete(h);
               end
            end else if (rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0) begin
               bad++;
               $display("FAIL idle_outputs inst=%0d got data=%h err=%b want 0 0", k, rsp_rdata[k], rsp_err[k]);
            end
         end
      end
   end

   task automatic push_exp(input int k, input int ch, input bit wr, input logic [3:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      e.inst = k; e.ch = ch; e.cyc = cyc + lat(k);
      if (int'(addr) >= ms(k)) begin
         e.err = 1'b1; e.data = 32'h0;
      end else begin
         e.err = 1'b0;
         if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[k][addr][b*8 +: 8] = wd[b*8 +: 8];
            e.data = 32'h0;
         end else begin
            e.data = model[k][addr];
         end
      end
      sb.push_back(e);
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic drive(input int k, input int ch, input bit wr, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
      int n;
      req_valid[k]                = 2'b00;
      req_valid[k][ch]            = 1'b1;
      req_wr[k][ch]               = wr;
      req_addr[k][ch*4 +: 4]      = addr;
      req_wdata[k][ch*32 +: 32]   = wd;
      req_be[k][ch*4 +: 4]        = be;
      #1;
      n = 0;
      while (req_ready[k][ch] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL accept_timeout inst=%0d ch=%0d got ready=%b want ready", k, ch, req_ready[k]);
      end else begin
         push_exp(k, ch, wr, addr, wd, be);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      req_valid[k] = 2'b00;
   endtask

   task automatic wait_drain(input int k);
      int n = 0;
      while (find_head(k) >= 0 && n < 20) begin
         @(negedge clk); n++;
      end
      total++;
      if (find_head(k) >= 0) begin
         bad++;
         $display("FAIL drain_timeout inst=%0d got pending=%0d want 0", k, sb.size());
      end
   endtask

   task automatic rst(input int k, input int n);
      reset[k] = 1'b1;
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].inst == k) sb.delete(i);
      for (int a = 0; a < 16; a++) model[k][a] = 32'h0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid[k] !== 2'b00 || rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0 || req_ready[k] !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs inst=%0d got valid=%b data=%h err=%b ready=%b want all 0",
                     k, rsp_valid[k], rsp_rdata[k], rsp_err[k], req_ready[k]);
         end
      end
      req_valid[k] = 2'b00;
      reset[k]     = 1'b0;
   endtask

   task automatic test_reset;
      drive(0, 0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
      idle(0);
      wait_drain(0);
      req_valid[0] = 2'b11;
      rst(0, 2);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid[0] !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_valid got %b want 00", rsp_valid[0]);
         end
      end
      drive(0, 0, 1'b0, 4'd3, 32'h0, 4'h0);
      idle(0);
      wait_drain(0);
   endtask

   task automatic test_byte_enable;
      drive(0, 0, 1'b1, 4'd5, 32'h11223344, 4'hF);
      drive(0, 1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
      drive(0, 0, 1'b0, 4'd5, 32'h0, 4'h0);
      idle(0);
      wait_drain(0);
      total++;
      if (model[0][5] !== 32'h11BB33DD) begin
         bad++;
         $display("FAIL be_model got %h want 11bb33dd", model[0][5]);
      end
   endtask

   task automatic test_back_to_back;
      drive(0, 1, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF);
      drive(0, 0, 1'b0, 4'd7, 32'h0, 4'h0);
      drive(0, 1, 1'b1, 4'd7, 32'h0000BEEF, 4'b0011);
      drive(0, 1, 1'b0, 4'd7, 32'h0, 4'h0);
      idle(0);
      wait_drain(0);
   endtask

   task automatic test_arbitration;
      logic [1:0] want;
      rst(0, 2);
      drive(0, 0, 1'b1, 4'd1, 32'hA1A1A1A1, 4'hF);
      drive(0, 1, 1'b1, 4'd2, 32'hB2B2B2B2, 4'hF);
      req_wr[0]    = 2'b00;
      req_addr[0]  = {4'd2, 4'd1};
      req_valid[0] = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         want = (i % 2 == 0) ? 2'b01 : 2'b10;
         total++;
         if (req_ready[0] !== want) begin
            bad++;
            $display("FAIL arb_both step=%0d got ready=%b want %b", i, req_ready[0], want);
         end
         push_exp(0, (i % 2), 1'b0, (i % 2 == 0) ? 4'd1 : 4'd2, 32'h0, 4'h0);
         @(negedge clk);
      end
      req_valid[0] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (req_ready[0] !== 2'b10) begin
            bad++;
            $display("FAIL arb_single step=%0d got ready=%b want 10", i, req_ready[0]);
         end
         push_exp(0, 1, 1'b0, 4'd2, 32'h0, 4'h0);
         @(negedge clk);
      end
      idle(0);
      wait_drain(0);
   endtask

   task automatic test_latency;
      for (int a = 0; a < 12; a++) begin
         drive(1, a % 2, 1'b1, 4'(a), 32'h10000000 + 32'(a) * 32'h111, 4'hF);
      end
      for (int a = 0; a < 4; a++) begin
         drive(1, 0, 1'b0, 4'(a), 32'h0, 4'h0);
      end
      idle(1);
      wait_drain(1);
   endtask

   task automatic test_range;
      drive(1, 0, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF);
      drive(1, 1, 1'b0, 4'd13, 32'h0, 4'h0);
      for (int a = 0; a < 12; a++) begin
         drive(1, 0, 1'b0, 4'(a), 32'h0, 4'h0);
      end
      idle(1);
      wait_drain(1);
   endtask

   task automatic test_reset_midflight;
      drive(2, 0, 1'b1, 4'd4, 32'h5A5A0001, 4'hF);
      idle(2);
      wait_drain(2);
      drive(2, 1, 1'b0, 4'd4, 32'h0, 4'h0);
      idle(2);
      rst(2, 2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (rsp_valid[2] !== 2'b00) begin
            bad++;
            $display("FAIL midflight_valid step=%0d got %b want 00", i, rsp_valid[2]);
         end
      end
      drive(2, 0, 1'b0, 4'd4, 32'h0, 4'h0);
      idle(2);
      wait_drain(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         reset[k] = 1'b1; req_valid[k] = '0; req_wr[k] = '0;
         req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
         for (int a = 0; a < 16; a++) model[k][a] = 32'h0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) reset[k] = 1'b0;
      mon_on = 1'b1;
      test_reset;
      test_byte_enable;
      test_back_to_back;
      test_arbitration;
      test_latency;
      test_range;
      test_reset_midflight;
      repeat (5) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover_expectations got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
